ext_mem_spi_ctrl: RTL and testbench

Single-lane SPI master (mode 0) for the external PSRAM/flash, sitting directly upstream of the four per-pin IOBUFFERs.
- Accepts one 32-bit word read or write per request via valid/ready.
- Serialises command, 24-bit address and data onto pad lane 0; captures read data from lane 1.
- Drives per-lane dir/out and samples the per-lane in returned by the pads.
- Lanes 2/3 (WP#/HOLD#) are held driven high.

---
 rtl/ext_mem_spi_pkg.sv | 28 ++
 rtl/ext_mem_spi_ctrl_clk_div.sv | 38 +++
 rtl/ext_mem_spi_ctrl.sv | 142 ++++++++++++++
 tb/tb_ext_mem_spi_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_spi_pkg.sv
// Shared types and constants for the external-memory SPI master.
// States, pad lane indices, default opcodes and frame length.
package ext_mem_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_DONE
    } state_t;

    localparam int LANE_MOSI = 0;
    localparam int LANE_MISO = 1;
    localparam int LANE_WP   = 2;
    localparam int LANE_HOLD = 3;

    localparam logic [7:0] CMD_READ_DEF  = 8'h03;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

    localparam int TOTAL_BITS = 64;

    // Data travels byte0 first, so the wire order is the byte-reversed word.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ext_mem_spi_ctrl_clk_div.sv
// SCLK generator: half-period counter running only while enabled.
// Ports: clock, reset, enable in; sclk, rise_strobe, fall_strobe out.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic sclk,
    output logic rise_strobe,
    output logic fall_strobe
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt;
    logic at_last;

    assign at_last = (cnt == LAST);

    // Strobes flag the cycle whose closing edge flips sclk.
    assign rise_strobe = enable && at_last && !sclk;
    assign fall_strobe = enable && at_last && sclk;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (at_last) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ext_mem_spi_ctrl.sv
// Single-lane mode-0 SPI master: one 32-bit read/write per request.
// Ports: clock/reset, req_* handshake, resp_*, spi_sclk/cs_n, io_dir/out/in.
module ext_mem_spi_ctrl
    import ext_mem_spi_pkg::*;
#(
    parameter int         CLK_DIV   = 2,
    parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic [3:0]  io_dir,
    output logic [3:0]  io_out,
    input  logic [3:0]  io_in
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    state_t                  state;
    logic                    we_q;
    logic                    mosi;
    logic [TOTAL_BITS-1:0]   tx_sreg;
    logic [TOTAL_BITS-1:0]   tx_load;
    logic [31:0]             rx_sreg;
    logic [6:0]              bit_cnt;
    logic [DW-1:0]           wait_cnt;
    logic                    rise;
    logic                    fall;
    logic                    unused_in;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clock       (clock),
        .reset       (reset),
        .enable      (state == ST_SHIFT),
        .sclk        (spi_sclk),
        .rise_strobe (rise),
        .fall_strobe (fall)
    );

    // Reads send zeros in the data phase.
    always_comb begin
        tx_load = {req_we ? CMD_WRITE : CMD_READ, req_addr,
                   req_we ? bswap32(req_wdata) : 32'h0};
    end

    always_comb begin
        io_dir            = '0;
        io_dir[LANE_MOSI] = 1'b1;
        io_dir[LANE_WP]   = 1'b1;
        io_dir[LANE_HOLD] = 1'b1;
        io_out            = '0;
        io_out[LANE_MOSI] = mosi;
        io_out[LANE_WP]   = 1'b1;
        io_out[LANE_HOLD] = 1'b1;
    end

    assign unused_in = ^{io_in[LANE_MOSI], io_in[LANE_WP], io_in[LANE_HOLD]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            spi_cs_n   <= 1'b1;
            mosi       <= 1'b0;
            we_q       <= 1'b0;
            tx_sreg    <= '0;
            rx_sreg    <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        tx_sreg   <= tx_load;
                        mosi      <= tx_load[TOTAL_BITS-1];
                        we_q      <= req_we;
                        spi_cs_n  <= 1'b0;
                        req_ready <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= ST_CS_SETUP;
                    end
                end
                ST_CS_SETUP: begin
                    if (wait_cnt == LAST) begin
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Only the final 32 captured bits survive: the data phase.
                    if (rise) begin
                        rx_sreg <= {rx_sreg[30:0], io_in[LANE_MISO]};
                    end
                    if (fall) begin
                        if (bit_cnt == 7'(TOTAL_BITS - 1)) begin
                            wait_cnt <= '0;
                            state    <= ST_CS_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_sreg <= tx_sreg << 1;
                            mosi    <= tx_sreg[TOTAL_BITS-2];
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (wait_cnt == LAST) begin
                        spi_cs_n   <= 1'b1;
                        resp_valid <= 1'b1;
                        if (!we_q) begin
                            resp_rdata <= bswap32(rx_sreg);
                        end
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    req_ready <= 1'b1;
                    mosi      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_spi_ctrl.sv
// Self-checking bench for ext_mem_spi_ctrl at CLK_DIV=2 and CLK_DIV=1.
// Cycle-level transaction model plus directed literal checks.
module tb_ext_mem_spi_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_a      [2];
    logic        req_valid_a  [2];
    logic        req_ready_a  [2];
    logic        req_we_a     [2];
    logic [23:0] req_addr_a   [2];
    logic [31:0] req_wdata_a  [2];
    logic        resp_valid_a [2];
    logic [31:0] resp_rdata_a [2];
    logic        sclk_a       [2];
    logic        cs_n_a       [2];
    logic [3:0]  io_dir_a     [2];
    logic [3:0]  io_out_a     [2];
    logic [3:0]  io_in_a      [2];

    ext_mem_spi_ctrl #(.CLK_DIV(2)) u_d2 (
        .clock      (clock),
        .reset      (reset_a[0]),
        .req_valid  (req_valid_a[0]),
        .req_ready  (req_ready_a[0]),
        .req_we     (req_we_a[0]),
        .req_addr   (req_addr_a[0]),
        .req_wdata  (req_wdata_a[0]),
        .resp_valid (resp_valid_a[0]),
        .resp_rdata (resp_rdata_a[0]),
        .spi_sclk   (sclk_a[0]),
        .spi_cs_n   (cs_n_a[0]),
        .io_dir     (io_dir_a[0]),
        .io_out     (io_out_a[0]),
        .io_in      (io_in_a[0])
    );

    ext_mem_spi_ctrl #(.CLK_DIV(1)) u_d1 (
        .clock      (clock),
        .reset      (reset_a[1]),
        .req_valid  (req_valid_a[1]),
        .req_ready  (req_ready_a[1]),
        .req_we     (req_we_a[1]),
        .req_addr   (req_addr_a[1]),
        .req_wdata  (req_wdata_a[1]),
        .resp_valid (resp_valid_a[1]),
        .resp_rdata (resp_rdata_a[1]),
        .spi_sclk   (sclk_a[1]),
        .spi_cs_n   (cs_n_a[1]),
        .io_dir     (io_dir_a[1]),
        .io_out     (io_out_a[1]),
        .io_in      (io_in_a[1])
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    always @(posedge clock) cyc++;

    // Slave's wire stream: 32 filler ones then bytes 0x11,0x22,0x33,0x44.
    logic [63:0] miso_stream = {32'hFFFF_FFFF, 8'h11, 8'h22, 8'h33, 8'h44};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    function automatic int divof(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // First data byte on the wire is the least significant byte.
    function automatic logic [31:0] read_word();
        return {miso_stream[7:0], miso_stream[15:8],
                miso_stream[23:16], miso_stream[31:24]};
    endfunction

    function automatic logic [63:0] build_stream(input bit we,
        input logic [23:0] a, input logic [31:0] d);
        logic [31:0] data;
        data = we ? {d[7:0], d[15:8], d[23:16], d[31:24]} : 32'h0;
        return {we ? 8'h02 : 8'h03, a, data};
    endfunction

    // Pad model: presents the next stream bit after each observed SCLK rise.
    int rises [2];
    bit pprev [2];
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_n_a[i] === 1'b1) rises[i] = 0;
            else if (sclk_a[i] === 1'b1 && !pprev[i]) rises[i]++;
            pprev[i] = (sclk_a[i] === 1'b1);
            io_in_a[i] = {2'b11,
                          (rises[i] < 64) ? miso_stream[63 - rises[i]] : 1'b0,
                          1'b0};
        end
    end

    // Transaction model and per-cycle compare.
    bit          busy   [2];
    int          acc    [2];
    bit          we_m   [2];
    logic [63:0] stream [2];
    logic [31:0] exp_rd [2];
    logic [63:0] cap    [2];
    int          nrise  [2];
    bit          mprev  [2];

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            int d;
            int rel;
            int k;
            int b;
            bit done_now;
            bit acc_now;
            bit exp_cs_n;
            bit exp_sclk;
            string p;
            d = divof(i);
            p = $sformatf("d%0d_", d);
            rel = cyc - acc[i];
            done_now = busy[i] && (rel == 130 * d + 1);
            if (done_now && !we_m[i]) exp_rd[i] = read_word();
            chk({p, "io_dir"}, 64'(io_dir_a[i]), 64'h0D);
            chk({p, "io_out_wp_hold"}, 64'(io_out_a[i][3:2]), 64'h3);
            chk({p, "req_ready"}, 64'(req_ready_a[i]), 64'(!busy[i]));
            chk({p, "resp_valid"}, 64'(resp_valid_a[i]), 64'(done_now));
            chk({p, "resp_rdata"}, 64'(resp_rdata_a[i]), 64'(exp_rd[i]));
            exp_cs_n = 1'b1;
            exp_sclk = 1'b0;
            if (busy[i]) begin
                k = rel - 1 - d;
                exp_cs_n = !(rel >= 1 && rel <= 130 * d);
                exp_sclk = (k >= 0) && (k < 128 * d) && ((k % (2 * d)) >= d);
                if (rel >= 1 && k < 128 * d) begin
                    b = (k < 0) ? 0 : k / (2 * d);
                    chk({p, "mosi"}, 64'(io_out_a[i][0]),
                        64'(stream[i][63 - b]));
                end
            end
            chk({p, "cs_n"}, 64'(cs_n_a[i]), 64'(exp_cs_n));
            chk({p, "sclk"}, 64'(sclk_a[i]), 64'(exp_sclk));
            if (cs_n_a[i] === 1'b0 && sclk_a[i] === 1'b1 && !mprev[i]) begin
                cap[i] = {cap[i][62:0], io_out_a[i][0]};
                nrise[i]++;
            end
            mprev[i] = (sclk_a[i] === 1'b1);
            acc_now = !busy[i] && req_valid_a[i] && !reset_a[i];
            if (done_now) busy[i] = 1'b0;
            if (acc_now) begin
                busy[i]   = 1'b1;
                acc[i]    = cyc;
                we_m[i]   = req_we_a[i];
                stream[i] = build_stream(req_we_a[i], req_addr_a[i],
                                         req_wdata_a[i]);
                cap[i]    = '0;
                nrise[i]  = 0;
            end
            if (reset_a[i]) begin
                busy[i]   = 1'b0;
                exp_rd[i] = '0;
            end
        end
    end

    task automatic start_req(input int i, input bit we,
        input logic [23:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        req_valid_a[i] = 1'b1;
        req_we_a[i]    = we;
        req_addr_a[i]  = a;
        req_wdata_a[i] = d;
    endtask

    task automatic wait_accept(input int i, output int c);
        c = -1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clock);
            if (req_ready_a[i] === 1'b1) begin
                c = cyc;
                return;
            end
        end
        chk("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_resp(input int i, output int c);
        c = -1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            if (resp_valid_a[i] === 1'b1) begin
                c = cyc;
                return;
            end
        end
        chk("resp_timeout", 64'd1, 64'd0);
    endtask

    // Request, drop valid and scramble the inputs while busy.
    task automatic run_txn(input int i, input bit we, input logic [23:0] a,
        input logic [31:0] d, output int ac, output int rc);
        start_req(i, we, a, d);
        wait_accept(i, ac);
        @(posedge clock); #1;
        req_valid_a[i] = 1'b0;
        req_we_a[i]    = ~we;
        req_addr_a[i]  = 24'hFFFFFF;
        req_wdata_a[i] = 32'hDEAD_BEEF;
        wait_resp(i, rc);
    endtask

    initial begin
        int a;
        int r;
        int a2;
        int r2;
        bit saw;
        for (int i = 0; i < 2; i++) begin
            reset_a[i]     = 1'b1;
            req_valid_a[i] = 1'b0;
            req_we_a[i]    = 1'b0;
            req_addr_a[i]  = '0;
            req_wdata_a[i] = '0;
            io_in_a[i]     = '0;
            busy[i]        = 1'b0;
            acc[i]         = 0;
            exp_rd[i]      = '0;
            cap[i]         = '0;
            nrise[i]       = 0;
        end
        repeat (3) @(posedge clock);
        #1;
        reset_a[0] = 1'b0;
        reset_a[1] = 1'b0;

        @(negedge clock);
        chk("reset_ready", 64'(req_ready_a[0]), 64'd1);
        chk("reset_cs_n", 64'(cs_n_a[0]), 64'd1);
        chk("reset_io_out", 64'(io_out_a[0]), 64'hC);

        run_txn(0, 1'b1, 24'h001234, 32'hA5C3_0F81, a, r);
        chk("wr_latency", 64'(r - a), 64'd261);
        chk("wr_stream", cap[0], 64'h0200_1234_810F_C3A5);
        chk("wr_rises", 64'(nrise[0]), 64'd64);

        run_txn(0, 1'b0, 24'h000010, 32'h0, a, r);
        chk("rd_latency", 64'(r - a), 64'd261);
        chk("rd_rdata", 64'(resp_rdata_a[0]), 64'h4433_2211);
        chk("rd_cmd_addr", 64'(cap[0][63:32]), 64'h0300_0010);
        chk("rd_mosi_zero", 64'(cap[0][31:0]), 64'h0);

        start_req(0, 1'b0, 24'h000020, 32'h0);
        wait_accept(0, a);
        @(posedge clock); #1;
        req_we_a[0]    = 1'b1;
        req_addr_a[0]  = 24'h0ABCDE;
        req_wdata_a[0] = 32'h1234_5678;
        wait_resp(0, r);
        chk("b2b_rd_rdata", 64'(resp_rdata_a[0]), 64'h4433_2211);
        wait_accept(0, a2);
        chk("b2b_accept_gap", 64'(a2 - r), 64'd1);
        @(posedge clock); #1;
        req_valid_a[0] = 1'b0;
        wait_resp(0, r2);
        chk("b2b_wr_latency", 64'(r2 - a2), 64'd261);
        chk("b2b_wr_stream", cap[0], 64'h020A_BCDE_7856_3412);
        chk("b2b_rdata_held", 64'(resp_rdata_a[0]), 64'h4433_2211);

        start_req(0, 1'b0, 24'h000040, 32'h0);
        wait_accept(0, a);
        @(posedge clock); #1;
        req_valid_a[0] = 1'b0;
        repeat (82) @(posedge clock);
        #1;
        reset_a[0] = 1'b1;
        @(posedge clock); #1;
        reset_a[0] = 1'b0;
        @(negedge clock);
        chk("rst_cs_n", 64'(cs_n_a[0]), 64'd1);
        chk("rst_sclk", 64'(sclk_a[0]), 64'd0);
        chk("rst_ready", 64'(req_ready_a[0]), 64'd1);
        chk("rst_rdata", 64'(resp_rdata_a[0]), 64'd0);
        saw = 1'b0;
        repeat (300) begin
            @(negedge clock);
            if (resp_valid_a[0] !== 1'b0) saw = 1'b1;
        end
        chk("rst_no_resp", 64'(saw), 64'd0);
        run_txn(0, 1'b0, 24'h000010, 32'h0, a, r);
        chk("rst_rd_latency", 64'(r - a), 64'd261);
        chk("rst_rd_rdata", 64'(resp_rdata_a[0]), 64'h4433_2211);

        run_txn(1, 1'b1, 24'h000100, 32'hFFFF_0000, a, r);
        chk("d1_wr_latency", 64'(r - a), 64'd131);
        chk("d1_wr_stream", cap[1], 64'h0200_0100_0000_FFFF);
        chk("d1_wr_rises", 64'(nrise[1]), 64'd64);

        run_txn(1, 1'b0, 24'h000200, 32'h0, a, r);
        chk("d1_rd_latency", 64'(r - a), 64'd131);
        chk("d1_rd_rdata", 64'(resp_rdata_a[1]), 64'h4433_2211);

        repeat (4) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
